// File: rtl/dftprobe_chain.sv
// Purpose : serial DFT probe chain; capture channel inputs, shift them out on tdo, update a hold register that drives o.
// Latency : capture/update take one cycle, shift takes NCH cycles; done pulses the cycle after the final edge.
// Backpress: none; requests arriving while busy are dropped rather than queued, so callers must wait for done.
//
// Ports:
//   CELCLK / CELRSTN      clock, asynchronous active-low reset
//   CELV / CELG / CELSUB  supply, ground and substrate pins (no logic function)
//   i / o                 per-channel functional input; output is i (ten=0) or the hold register (ten=1)
//   ten                   test enable (0 = functional pass-through, all requests ignored)
//   tdi / tdo             serial test data in / out (tdo is always the shift register LSB)
//   cap / shf / upd       capture, shift and update requests, sampled only in IDLE (cap > shf > upd)
//   busy / done           FSM not idle / one-cycle completion pulse
module dftprobe_chain #(
    parameter int NCH  = 8,    // 2..64 channels
    parameter int CNTW = 4     // 2**CNTW must exceed NCH so the counter can hold NCH
) (
    input  logic           CELCLK,
    input  logic           CELRSTN,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           CELSUB,
    input  logic [NCH-1:0] i,
    output logic [NCH-1:0] o,
    input  logic           ten,
    input  logic           tdi,
    output logic           tdo,
    input  logic           cap,
    input  logic           shf,
    input  logic           upd,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        SHIFT = 2'd2,
        UPDT  = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(NCH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t          state_q, state_d;
    logic [NCH-1:0]  sr_q, sr_d;
    logic [NCH-1:0]  hr_q, hr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    // Power pins exist only for the physical cell footprint; fold them into a
    // deliberately unused net so they stay visibly connected in the netlist.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ CELSUB;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        hr_d    = hr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Requests are only honoured in test mode; functional mode
                // leaves the chain completely untouched.
                if (ten) begin
                    if (cap) begin
                        state_d = CAPT;
                    end else if (shf) begin
                        state_d = SHIFT;
                        cnt_d   = CNT_LOAD;
                    end else if (upd) begin
                        state_d = UPDT;
                    end
                end
            end

            CAPT: begin
                state_d = IDLE;
                if (ten) begin
                    sr_d   = i;
                    done_d = 1'b1;
                end
            end

            SHIFT: begin
                // Leaving test mode mid-shift aborts silently: no shift on
                // this edge, partial contents retained, no done pulse.
                if (!ten) begin
                    state_d = IDLE;
                end else begin
                    sr_d  = {tdi, sr_q[NCH-1:1]};
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            UPDT: begin
                state_d = IDLE;
                if (ten) begin
                    hr_d   = sr_q;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q <= IDLE;
            sr_q    <= '0;
            hr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            hr_q    <= hr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign o    = ten ? hr_q : i;
    assign tdo  = sr_q[0];
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_dftprobe_chain.sv
// Purpose : self-checking bench for dftprobe_chain (NCH=8) using an operation scoreboard.
// Latency : expected results are queued when a request is driven and popped once done is observed.
// Backpress: every wait on the DUT is cycle-bounded; an expired bound shows up as a failed check.
module tb_dftprobe_chain;

    localparam int NCH = 8;

    localparam int OP_CAP    = 0;
    localparam int OP_SHF    = 1;
    localparam int OP_UPD    = 2;
    localparam int OP_CAPSHF = 3;

    typedef struct {
        logic [NCH-1:0] sr;
        logic [NCH-1:0] hr;
        int             busy_n;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] i;
    logic [NCH-1:0] o;
    logic           ten;
    logic           tdi;
    logic           tdo;
    logic           cap;
    logic           shf;
    logic           upd;
    logic           busy;
    logic           done;

    exp_t           sb_q[$];
    logic [NCH-1:0] m_sr;
    logic [NCH-1:0] m_hr;
    int             n_chk;
    int             n_pass;

    dftprobe_chain #(.NCH(NCH), .CNTW(4)) dut (
        .CELCLK  (clk),
        .CELRSTN (rst_n),
        .CELV    (1'b1),
        .CELG    (1'b0),
        .CELSUB  (1'b0),
        .i       (i),
        .o       (o),
        .ten     (ten),
        .tdi     (tdi),
        .tdo     (tdo),
        .cap     (cap),
        .shf     (shf),
        .upd     (upd),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one request (ten=1), follow it to its done pulse and score it.
    // noise=1 holds every request line high while busy to prove they are dropped.
    task automatic run_op(input int kind, input logic [NCH-1:0] seq, input bit noise);
        exp_t           e;
        exp_t           got;
        logic [NCH-1:0] ts;
        int             busy_n;
        int             k;
        bit             seen;
        busy_n = 0;
        k      = 0;
        seen   = 1'b0;
        ts     = m_sr;
        case (kind)
            OP_CAP, OP_CAPSHF: begin
                m_sr     = i;
                e.busy_n = 1;
            end
            OP_SHF: begin
                for (int b = 0; b < NCH; b++) m_sr = {seq[b], m_sr[NCH-1:1]};
                e.busy_n = NCH;
            end
            default: begin
                m_hr     = m_sr;
                e.busy_n = 1;
            end
        endcase
        e.sr = m_sr;
        e.hr = m_hr;
        sb_q.push_back(e);

        @(negedge clk);
        cap = (kind == OP_CAP) || (kind == OP_CAPSHF);
        shf = (kind == OP_SHF) || (kind == OP_CAPSHF);
        upd = (kind == OP_UPD);
        @(negedge clk);
        cap = noise;
        shf = noise || (kind == OP_CAPSHF);
        upd = noise;
        for (int c = 0; c < 4 * NCH && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) begin
                    busy_n++;
                    if (kind == OP_SHF && k < NCH) begin
                        chk("tdo_bit", tdo, ts[0]);
                        tdi = seq[k];
                        ts  = {seq[k], ts[NCH-1:1]};
                        k++;
                    end
                end
                @(negedge clk);
            end
        end
        // Drop requests in the done cycle so nothing gets sampled back in IDLE.
        cap = 1'b0;
        shf = 1'b0;
        upd = 1'b0;
        tdi = 1'b0;
        chk("done_seen", seen, 1);
        got = sb_q.pop_front();
        chk("busy_cycles", busy_n, got.busy_n);
        chk("sr", dut.sr_q, got.sr);
        chk("hr", dut.hr_q, got.hr);
        chk("o_test", o, got.hr);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        logic [NCH-1:0] seq;
        n_chk  = 0;
        n_pass = 0;
        m_sr   = '0;
        m_hr   = '0;
        rst_n  = 1'b0;
        ten    = 1'b1;
        i      = 8'h5A;
        tdi    = 1'b0;
        cap    = 1'b0;
        shf    = 1'b0;
        upd    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tdo", tdo, 0);
        chk("rst_o_ten1", o, 8'h00);
        ten = 1'b0;
        #1;
        chk("rst_o_ten0", o, 8'h5A);
        @(negedge clk);
        rst_n = 1'b1;

        // Functional mode: pass-through, requests ignored
        i = 8'hA5;
        @(negedge clk);
        chk("func_o", o, 8'hA5);
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        chk("func_cap_busy", busy, 0);
        shf = 1'b1;
        @(negedge clk);
        shf = 1'b0;
        chk("func_shf_busy", busy, 0);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        chk("func_upd_busy", busy, 0);
        @(negedge clk);
        chk("func_sr", dut.sr_q, 8'h00);
        chk("func_hr", dut.hr_q, 8'h00);

        // Capture
        ten = 1'b1;
        i   = 8'h3C;
        #1;
        chk("cap_o_before", o, 8'h00);
        run_op(OP_CAP, 8'h00, 1'b0);
        chk("cap_sr_const", dut.sr_q, 8'h3C);
        chk("cap_tdo", tdo, 0);
        chk("cap_o_const", o, 8'h00);

        // Shift in 1,0,1,1,0,0,1,0 (first bit in seq[0])
        run_op(OP_SHF, 8'h4D, 1'b0);
        chk("shf_sr_const", dut.sr_q, 8'h4D);

        // Update with stray requests held while busy
        run_op(OP_UPD, 8'h00, 1'b1);
        chk("upd_hr_const", dut.hr_q, 8'h4D);
        chk("upd_o_const", o, 8'h4D);
        ten = 1'b0;
        i   = 8'h96;
        #1;
        chk("upd_o_func", o, 8'h96);
        ten = 1'b1;

        // cap+shf together: capture wins, held shf dropped
        i = 8'hE7;
        run_op(OP_CAPSHF, 8'h00, 1'b0);
        chk("prio_sr_const", dut.sr_q, 8'hE7);

        // Random shifts with requests held during busy
        for (int r = 0; r < 3; r++) begin
            seq = NCH'($urandom);
            run_op(OP_SHF, seq, 1'b1);
            run_op(OP_UPD, 8'h00, 1'b0);
        end

        // ten dropped after three shifts
        @(negedge clk);
        shf = 1'b1;
        @(negedge clk);
        shf = 1'b0;
        seq = 8'b0000_0101;
        for (int b = 0; b < 3; b++) begin
            tdi  = seq[b];
            m_sr = {seq[b], m_sr[NCH-1:1]};
            @(negedge clk);
        end
        chk("abort_busy_before", busy, 1);
        ten = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_sr", dut.sr_q, m_sr);
        chk("abort_hr", dut.hr_q, m_hr);
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        @(negedge clk);
        chk("ten0_cap_busy", busy, 0);
        chk("ten0_cap_sr", dut.sr_q, m_sr);
        ten = 1'b1;

        // Asynchronous reset in the middle of a shift
        tdi = 1'b1;
        @(negedge clk);
        shf = 1'b1;
        @(negedge clk);
        shf = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_sr  = '0;
        m_hr  = '0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tdo", tdo, 0);
        chk("arst_sr", dut.sr_q, 8'h00);
        chk("arst_hr", dut.hr_q, 8'h00);
        chk("arst_o", o, 8'h00);
        tdi = 1'b0;

        // First request after release is taken on the first rising edge
        @(negedge clk);
        i     = 8'h81;
        rst_n = 1'b1;
        cap   = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        chk("rel_first_busy", busy, 1);
        @(negedge clk);
        chk("rel_done", done, 1);
        chk("rel_sr", dut.sr_q, 8'h81);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
